cpu_in_port: RTL



---
 rtl/cpu_in_port.sv | 117 +++++++++++
 1 files changed

// File: rtl/cpu_in_port.sv
// cpu_in_port: synchronizes and debounces 8 raw board inputs and presents
// one stable byte to the CPU for an IN-style read.
//
// Optional feature macro: CPU_IN_EDGE_EN
//   When defined, adds rise_o: sticky per-bit 0->1 flags captured whenever
//   in_value_o loads, cleared together with in_valid_o on acknowledge.
//
// Handshake (valid/ack): in_valid_o rises on the edge where a new stable
// value loads into in_value_o and stays high until the CPU pulses in_ack_i
// while in_valid_o is high. An ack on the same cycle as a new load keeps
// in_valid_o high so the new value is not lost. A later load may overwrite
// an unacknowledged value; only the latest value is kept. An ack while
// in_valid_o is low has no effect.
module cpu_in_port #(
    parameter int ACTIVE_LOW   = 1,
    parameter int TICK_BITS    = 14,
    parameter int STABLE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [7:0] pins_i,
    input  logic       in_ack_i,
    output logic [7:0] in_value_o,
    output logic       in_valid_o,
`ifdef CPU_IN_EDGE_EN
    output logic [7:0] rise_o,
`endif
    output logic       busy_o
);

    localparam logic [7:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0] ST         = 4'(STABLE_TICKS);

    logic [7:0]           sync1;
    logic [7:0]           sync2;
    logic [7:0]           s;
    logic [TICK_BITS-1:0] tick_cnt;
    logic                 tick;
    logic [7:0]           cand;
    logic [3:0]           stable_cnt;
    logic                 accept;
    logic                 load;
    logic                 ack_take;

    // Two-flop synchronizer; resets to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= pins_i;
            sync2 <= sync1;
        end
    end

    assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    // Free-running prescaler producing one sample tick every 2**TICK_BITS cycles.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = &tick_cnt;

    // Debounce: restart the run on a changed sample, count identical samples up to saturation.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cand       <= 8'h00;
            stable_cnt <= ST;
        end else if (tick) begin
            if (s != cand) begin
                cand       <= s;
                stable_cnt <= 4'd1;
            end else if (stable_cnt < ST) begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

    // A run that just reached the required length is accepted exactly once.
    assign accept   = tick && (s == cand) && (stable_cnt < ST) && ((stable_cnt + 4'd1) == ST);
    assign load     = accept && (cand != in_value_o);
    assign ack_take = in_ack_i && in_valid_o;

    // Output register and valid flag; a new load wins over a simultaneous ack.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            in_value_o <= 8'h00;
            in_valid_o <= 1'b0;
        end else if (load) begin
            in_value_o <= cand;
            in_valid_o <= 1'b1;
        end else if (ack_take) begin
            in_valid_o <= 1'b0;
        end
    end

`ifdef CPU_IN_EDGE_EN
    // Sticky rising-edge flags; bits set by a load take priority over the ack clear.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            rise_o <= 8'h00;
        end else if (load) begin
            rise_o <= (ack_take ? 8'h00 : rise_o) | (cand & ~in_value_o);
        end else if (ack_take) begin
            rise_o <= 8'h00;
        end
    end
`endif

    assign busy_o = (cand != in_value_o);

endmodule
